buffer_pop_ctrl: RTL
====================

// Module: buffer_pop_ctrl
// PURPOSE
//  Drain stage directly downstream of the buffer. Issues pop_en/pop to the buffer, captures its
//  registered data_out one cycle later into a SKID_DEPTH-entry output queue, and presents a
//  valid/ready stream to the consumer. Prevents buffer err: never pops when empty, pops only when
//  no upstream push is in the same cycle, and never exceeds skid credit.
// PARAMETERS
//  DATA_WIDTH  8  width of buffer data and m_data
//  SKID_DEPTH  2  output queue entries, >= 2; covers 1-cycle buffer read latency at full rate
// PORTS
//  clk           in   1           clock, all state on rising edge
//  rst_n         in   1           reset: synchronous, active-high (1 = reset)
//  enable        in   1           1 = allowed to pop; 0 = stop issuing pops, drain what is in flight
//  up_push       in   1           upstream push to the buffer this cycle (push & push_en)
//  buf_is_empty  in   1           buffer is_empty
//  buf_data      in   DATA_WIDTH  buffer data_out (valid cycle after pop)
//  buf_err       in   1           buffer err (registered)
//  err_clr       in   1           clears sticky error, returns FSM to IDLE
//  pop_en        out  1           to buffer; equals pop
//  pop           out  1           to buffer; combinational from current state and inputs
//  m_valid       out  1           output queue head valid
//  m_data        out  DATA_WIDTH  output queue head
//  m_ready       in   1           consumer accepts head when m_valid & m_ready
//  occupancy     out  $clog2(SKID_DEPTH+1)  entries held in output queue
//  err_sticky    out  1           latched buf_err
// BEHAVIOUR
//  Reset (rst_n=1 at edge): state=IDLE, pop/pop_en=0, m_valid=0, m_data=0, occupancy=0,
//   err_sticky=0, inflight=0, queue pointers=0. Reset mid-transfer drops in-flight/queued data.
//  FSM: IDLE -> RUN when enable=1 & err_sticky=0. RUN -> DRAIN when enable=0.
//   DRAIN -> IDLE when inflight=0 & occupancy=0; DRAIN -> RUN if enable returns to 1.
//   Any state -> ERR when buf_err=1 (err_sticky<=1). ERR -> IDLE on err_clr=1 (err_sticky<=0);
//   queued entries retained in ERR and still drainable by consumer.
//  pop = (state==RUN) & ~buf_is_empty & ~up_push & (occupancy + inflight - deq < SKID_DEPTH),
//   deq = m_valid & m_ready. pop_en == pop always.
//  inflight: 1-bit reg, <= pop. When inflight=1, enqueue buf_data at that edge (1-cycle latency:
//   pop in cycle N -> data captured at end of cycle N+1 -> m_valid earliest cycle N+2).
//  Queue: circular, wr/rd pointers wrap at SKID_DEPTH-1 -> 0. Simultaneous enq and deq:
//   occupancy unchanged, both pointers advance; deq of head and enq never collide (credit check).
//  Full queue: pop held 0; consumer stall never causes overflow. Empty queue: m_valid=0, m_data holds
//   last value (don't-care to consumer).
//  Back-to-back pops allowed every cycle in RUN while credit and ~buf_is_empty; sustained
//   throughput 1 word/cycle with SKID_DEPTH>=2 and m_ready=1.
//  up_push=1 suppresses pop that cycle only (buffer forbids simultaneous push/pop).
//  In-flight pop completing in DRAIN/ERR is still enqueued (no data loss).
//  Assertions: never pop while buf_is_empty; never enq when occupancy==SKID_DEPTH & ~deq.
// TESTING
//  1 Reset: rst_n=1 two edges, enable=1 -> pop=0, m_valid=0, occupancy=0, err_sticky=0.
//  2 Stream: buffer preloaded 1..8, enable=1, m_ready=1 -> pop 8 consecutive cycles, m_data
//    1..8 on consecutive cycles starting 2 cycles after first pop, no buf_err.
//  3 Backpressure: m_ready=0 with 8 words -> exactly SKID_DEPTH pops, occupancy=2, pop=0 after;
//    release m_ready -> order 1..8 preserved, no drops or duplicates.
//  4 Push collision: up_push=1 on cycles 3,4 during streaming -> pop=0 those cycles, buf_err stays 0.
//  5 Disable/drain: enable 1->0 one cycle after a pop -> that word still delivered, state reaches
//    IDLE with occupancy=0, no further pops.
//  6 Error: force buf_err=1 -> err_sticky=1, pop=0 until err_clr; err_clr -> IDLE, err_sticky=0,
//    RUN resumes next cycle with enable=1.

Source files
------------

// File: rtl/buffer_pop_ctrl.sv
// buffer_pop_ctrl: drain stage sitting directly behind a buffer with a
// one-cycle registered read port. It issues pops only when the buffer has
// data, no upstream push shares the cycle, and the skid queue has room for
// everything already committed. Returned words are captured into a small
// circular queue that feeds a valid/ready consumer stream.

// Safety properties for the pop controller, kept apart from the datapath.
module buffer_pop_ctrl_chk #(
  parameter int SKID_DEPTH = 2,
  parameter int CW         = 2
) (
  input logic          clk,
  input logic          rst_n,
  input logic          pop,
  input logic          up_push,
  input logic          buf_is_empty,
  input logic          enq,
  input logic          deq,
  input logic [CW-1:0] occupancy
);

  // Popping an empty buffer would trip the buffer's own error flag.
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst_n)
    !(pop && buf_is_empty));

  // The buffer forbids a push and a pop in the same cycle.
  a_no_pop_push: assert property (@(posedge clk) disable iff (rst_n)
    !(pop && up_push));

  // A returning word must always find a free slot in the skid queue.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst_n)
    !(enq && !deq && (occupancy == CW'(SKID_DEPTH))));

endmodule

module buffer_pop_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int SKID_DEPTH = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               enable,
  input  logic                               up_push,
  input  logic                               buf_is_empty,
  input  logic [DATA_WIDTH-1:0]              buf_data,
  input  logic                               buf_err,
  input  logic                               err_clr,
  output logic                               pop_en,
  output logic                               pop,
  output logic                               m_valid,
  output logic [DATA_WIDTH-1:0]              m_data,
  input  logic                               m_ready,
  output logic [$clog2(SKID_DEPTH+1)-1:0]    occupancy,
  output logic                               err_sticky
);

  localparam int CW = $clog2(SKID_DEPTH + 1);
  localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(SKID_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(SKID_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  state_t                state;
  logic                  inflight;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] mem [SKID_DEPTH];

  logic                  deq;
  logic                  enq;
  logic [CW:0]           credit_used;
  logic [PW-1:0]         rd_ptr_nxt;
  logic [CW-1:0]         occ_nxt;
  logic [DATA_WIDTH-1:0] head_nxt;

  // Circular pointer advance that wraps at the last queue slot.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    logic [PW-1:0] r;
    if (p == LAST_PTR) begin
      r = {PW{1'b0}};
    end else begin
      r = p + PW'(1);
    end
    return r;
  endfunction

  // Pop decision: credit counts queued words plus the word still in flight,
  // minus the head leaving this cycle, so a full-rate stream never overflows.
  always_comb begin
    deq         = m_valid & m_ready;
    enq         = inflight;
    credit_used = {1'b0, occupancy} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, deq};
    pop         = (state == ST_RUN) & ~buf_is_empty & ~up_push & (credit_used < DEPTH_W);
    pop_en      = pop;
  end

  // Next queue bookkeeping and the word that will sit at the head after this edge.
  always_comb begin
    occ_nxt  = occupancy;
    head_nxt = m_data;
    if (deq) begin
      rd_ptr_nxt = ptr_inc(rd_ptr);
    end else begin
      rd_ptr_nxt = rd_ptr;
    end
    case ({enq, deq})
      2'b10:   occ_nxt = occupancy + CW'(1);
      2'b01:   occ_nxt = occupancy - CW'(1);
      default: occ_nxt = occupancy;
    endcase
    // When the queue would otherwise be empty the arriving word becomes head.
    if (enq && (occupancy == CW'(deq))) begin
      head_nxt = buf_data;
    end else begin
      head_nxt = mem[rd_ptr_nxt];
    end
  end

  // Control FSM; a buffer error overrides every state and latches the sticky flag.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state      <= ST_IDLE;
      err_sticky <= 1'b0;
    end else if (buf_err) begin
      state      <= ST_ERR;
      err_sticky <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable && !err_sticky) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!enable) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (enable) begin
            state <= ST_RUN;
          end else if (!inflight && (occupancy == {CW{1'b0}})) begin
            state <= ST_IDLE;
          end
        end
        ST_ERR: begin
          if (err_clr) begin
            state      <= ST_IDLE;
            err_sticky <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Read-latency tracking and skid queue storage; in-flight words land in any state.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      inflight  <= 1'b0;
      wr_ptr    <= {PW{1'b0}};
      rd_ptr    <= {PW{1'b0}};
      occupancy <= {CW{1'b0}};
      m_valid   <= 1'b0;
      m_data    <= {DATA_WIDTH{1'b0}};
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      inflight <= pop;
      if (enq) begin
        mem[wr_ptr] <= buf_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      rd_ptr    <= rd_ptr_nxt;
      occupancy <= occ_nxt;
      m_valid   <= (occ_nxt != {CW{1'b0}});
      // An emptied queue keeps the last head value on m_data.
      if (occ_nxt != {CW{1'b0}}) begin
        m_data <= head_nxt;
      end
    end
  end

  buffer_pop_ctrl_chk #(
    .SKID_DEPTH (SKID_DEPTH),
    .CW         (CW)
  ) u_chk (
    .clk          (clk),
    .rst_n        (rst_n),
    .pop          (pop),
    .up_push      (up_push),
    .buf_is_empty (buf_is_empty),
    .enq          (enq),
    .deq          (deq),
    .occupancy    (occupancy)
  );

endmodule
